// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, the master FSM state type and the command legality check.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_DATA = 4'b0011;

  localparam int BEAT_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA_LAST,
    ST_ERR1
  } state_t;

  // Sizes above a word and addresses not aligned to the transfer size are refused.
  function automatic logic cmd_illegal(input logic [2:0] size, input logic [1:0] lsb);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && lsb[0]) ||
           ((size == HSIZE_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/ahb3lite_addr_gen.sv
// Beat counter and address incrementer for the current command.
module ahb3lite_addr_gen
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  load,
  input  logic [HADDR_SIZE-1:0] load_addr,
  input  logic [1:0]            size,
  input  logic                  incr4,
  input  logic                  step,
  output logic [HADDR_SIZE-1:0] addr,
  output logic [1:0]            beat,
  output logic                  last
);

  localparam logic [1:0] LAST_BEAT = 2'(BEAT_COUNT - 1);

  logic [HADDR_SIZE-1:0] incr;

  always_comb begin
    incr      = '0;
    incr[2:0] = 3'b001 << size;
  end

  assign last = !incr4 || (beat == LAST_BEAT);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr <= '0;
      beat <= '0;
    end else if (load) begin
      addr <= load_addr;
      beat <= '0;
    end else if (step) begin
      addr <= addr + incr;
      beat <= beat + 2'd1;
    end
  end

endmodule

// File: rtl/ahb3lite_master.sv
// AHB3-Lite master: turns SINGLE/INCR4 commands into pipelined bus transfers,
// one response per completed beat, one error response per aborted command.
//
// state        | meaning
// ST_IDLE      | ready for a command; reports a rejected command one cycle later
// ST_ADDR      | driving address phase of the current beat (NONSEQ/SEQ/BUSY)
// ST_DATA_LAST | last beat's data phase outstanding, bus address phase idle
// ST_ERR1      | second cycle of an ERROR response, remaining beats abandoned
module ahb3lite_master
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic                  cmd_incr4,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [HDATA_SIZE-1:0] wd_data,
  output logic                  rsp_valid,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_last,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  state_t     state, state_nxt;
  logic       run_q;
  logic       rej_q;
  logic       wr_q;
  logic       incr4_q;
  logic [2:0] size_q;
  logic       dp_valid, dp_write, dp_last;
  logic [1:0] beat;
  logic       last;
  logic       cmd_hs, cmd_bad, load, step;
  logic       beat_ok, addr_done, err_now;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign cmd_bad   = cmd_illegal(cmd_size, cmd_addr[1:0]);
  assign load      = cmd_hs && !cmd_bad;
  assign beat_ok   = !wr_q || wd_valid;
  assign addr_done = (state == ST_ADDR) && beat_ok && HREADY;
  assign step      = addr_done && !last;
  // First ERROR cycle: slave still stalling with HRESP raised.
  assign err_now   = dp_valid && HRESP && !HREADY;

  ahb3lite_addr_gen #(
    .HADDR_SIZE(HADDR_SIZE)
  ) u_addr_gen (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .load      (load),
    .load_addr (cmd_addr),
    .size      (size_q[1:0]),
    .incr4     (incr4_q),
    .step      (step),
    .addr      (HADDR),
    .beat      (beat),
    .last      (last)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (load) state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (err_now)               state_nxt = ST_ERR1;
        else if (addr_done && last) state_nxt = ST_DATA_LAST;
      end
      ST_DATA_LAST: begin
        if (err_now)     state_nxt = ST_ERR1;
        else if (HREADY) state_nxt = ST_IDLE;
      end
      ST_ERR1:      if (HREADY) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    HTRANS    = HTRANS_IDLE;
    cmd_ready = (state == ST_IDLE) && run_q;
    wd_ready  = (state == ST_ADDR) && wr_q && wd_valid && HREADY;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    rsp_last  = 1'b0;

    if ((state == ST_ADDR) && !err_now) begin
      if (beat_ok)          HTRANS = (beat == 2'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      else if (beat != 2'd0) HTRANS = HTRANS_BUSY;
    end

    if (rej_q) begin
      rsp_valid = 1'b1;
      rsp_err   = 1'b1;
      rsp_last  = 1'b1;
    end else if (state == ST_ERR1) begin
      rsp_valid = HREADY;
      rsp_err   = HREADY;
      rsp_last  = HREADY;
    end else if (dp_valid && HREADY) begin
      rsp_valid = 1'b1;
      rsp_rdata = dp_write ? '0 : HRDATA;
      rsp_last  = dp_last;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      run_q    <= 1'b0;
      rej_q    <= 1'b0;
      wr_q     <= 1'b0;
      incr4_q  <= 1'b0;
      size_q   <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_last  <= 1'b0;
      HWDATA   <= '0;
    end else begin
      run_q <= 1'b1;
      rej_q <= cmd_hs && cmd_bad;
      if (load) begin
        wr_q    <= cmd_write;
        size_q  <= cmd_size;
        incr4_q <= cmd_incr4;
      end
      if (HREADY) begin
        dp_valid <= addr_done;
        if (addr_done) begin
          dp_write <= wr_q;
          dp_last  <= last;
        end
      end
      // Captured only when a write address phase completes, held otherwise.
      if (wd_ready) HWDATA <= wd_data;
    end
  end

  assign HWRITE = wr_q;
  assign HSIZE  = size_q;
  assign HBURST = incr4_q ? HBURST_INCR4 : HBURST_SINGLE;
  assign HPROT  = HPROT_DATA;

endmodule

// File: tb/tb_ahb3lite_master.sv
// Directed bench for ahb3lite_master with a small zero-wait memory slave and ERROR injection.
module tb_ahb3lite_master;
  import ahb3lite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_incr4 = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic        cmd_ready;
  logic        wd_valid = 1'b0;
  logic [31:0] wd_data = '0;
  logic        wd_ready;
  logic        rsp_valid, rsp_err, rsp_last;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb3lite_master #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_incr4(cmd_incr4),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- memory slave ----------------
  logic [31:0] mem [64] = '{default: 32'h0};
  logic        s_act = 1'b0, s_wr = 1'b0;
  logic [31:0] s_addr = '0;
  logic [2:0]  s_size = '0;
  logic [1:0]  ecnt = '0;
  logic        err_arm = 1'b0;
  logic [31:0] err_addr = '0;

  assign HREADY = (ecnt != 2'd1);
  assign HRESP  = (ecnt != 2'd0);
  assign HRDATA = (s_act && !s_wr) ? mem[s_addr[7:2]] : 32'h0;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s_act <= 1'b0;
      ecnt  <= 2'd0;
    end else begin
      if (ecnt == 2'd1)      ecnt <= 2'd2;
      else if (ecnt == 2'd2) ecnt <= 2'd0;
      if (HREADY) begin
        if (s_act && s_wr && !HRESP) begin
          case (s_size)
            3'd0:    mem[s_addr[7:2]][8*s_addr[1:0] +: 8]  <= HWDATA[8*s_addr[1:0] +: 8];
            3'd1:    mem[s_addr[7:2]][16*s_addr[1] +: 16]  <= HWDATA[16*s_addr[1] +: 16];
            default: mem[s_addr[7:2]] <= HWDATA;
          endcase
        end
        s_act  <= HTRANS[1];
        s_addr <= HADDR;
        s_wr   <= HWRITE;
        s_size <= HSIZE;
        if (HTRANS[1] && err_arm && (HADDR == err_addr)) ecnt <= 2'd1;
      end
    end
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  typedef struct packed {
    logic [1:0]  t;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [2:0]  bu;
    logic        w;
    logic [31:0] c;
  } tr_t;
  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        l;
    logic [31:0] c;
  } rs_t;

  tr_t tq[$];
  rs_t rq[$];
  int  n_errcyc = 0;
  logic [1:0] errcyc_trans = 2'b11;
  int  rst_rsp = 0;

  always @(negedge HCLK) begin
    if (HTRANS != HTRANS_IDLE)
      tq.push_back('{t: HTRANS, a: HADDR, sz: HSIZE, bu: HBURST, w: HWRITE, c: 32'(cyc)});
    if (rsp_valid)
      rq.push_back('{d: rsp_rdata, e: rsp_err, l: rsp_last, c: 32'(cyc)});
    if (HRESP && !HREADY) begin
      n_errcyc     <= n_errcyc + 1;
      errcyc_trans <= HTRANS;
    end
    if (HRESET && rsp_valid) rst_rsp <= rst_rsp + 1;
  end

  function automatic tr_t tr_at(input int i);
    tr_t z;
    z = '0;
    if (i >= 0 && i < tq.size()) z = tq[i];
    return z;
  endfunction

  function automatic rs_t rs_at(input int i);
    rs_t z;
    z = '0;
    if (i >= 0 && i < rq.size()) z = rq[i];
    return z;
  endfunction

  // ---------------- drivers ----------------
  logic [31:0] wbuf [4];
  int t0 = 0, r0 = 0, hs_cyc = 0;

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic i4, output logic ok);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_incr4 = i4;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge HCLK);
      if (cmd_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
        break;
      end
    end
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int gb, input int gl, output int got);
    logic ok;
    got = 0;
    for (int k = 0; k < n; k++) begin
      if (k == gb) begin
        wd_valid = 1'b0;
        repeat (gl) @(posedge HCLK);
        #1;
      end
      wd_valid = 1'b1;
      wd_data  = wbuf[k];
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge HCLK);
        if (wd_ready) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge HCLK); #1;
      if (!ok) break;
      got++;
    end
    wd_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic i4, input int nb, input int gb, input int gl, input int exp_rsp);
    logic hs;
    int   got_wd;
    got_wd = 0;
    @(posedge HCLK); #1;
    t0 = tq.size();
    r0 = rq.size();
    fork
      send_cmd(wr, a, sz, i4, hs);
      begin
        if (wr) feed(nb, gb, gl, got_wd);
      end
    join
    chk({tag, "_hs"}, 32'(hs), 32'd1);
    if (wr) chk({tag, "_wd_beats"}, 32'(got_wd), 32'(nb));
    for (int i = 0; i < 60; i++) begin
      if (rq.size() - r0 >= exp_rsp) break;
      @(negedge HCLK);
    end
    repeat (3) @(negedge HCLK);
    chk({tag, "_nrsp"}, 32'(rq.size() - r0), 32'(exp_rsp));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tr_t tr;
    rs_t rs;
    logic hs;
    logic [1:0] exp_t [6];
    logic [31:0] exp_a [6];
    int  e0;

    repeat (2) @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hprot", 32'(HPROT), 32'h3);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wd_ready", 32'(wd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);

    // word SINGLE write then read
    wbuf[0] = 32'hDEADBEEF;
    run("wr1", 1'b1, 32'h10, 3'd2, 1'b0, 1, 9, 0, 1);
    tr = tr_at(t0); rs = rs_at(r0);
    chk("wr1_ntrans", 32'(tq.size() - t0), 32'd1);
    chk("wr1_htrans", 32'(tr.t), 32'(HTRANS_NONSEQ));
    chk("wr1_haddr", tr.a, 32'h10);
    chk("wr1_hburst", 32'(tr.bu), 32'd0);
    chk("wr1_hsize", 32'(tr.sz), 32'd2);
    chk("wr1_hwrite", 32'(tr.w), 32'd1);
    chk("wr1_addr_lat", tr.c - 32'(hs_cyc), 32'd1);
    chk("wr1_rsp_lat", rs.c - 32'(hs_cyc), 32'd2);
    chk("wr1_rdata", rs.d, 32'h0);
    chk("wr1_err", 32'(rs.e), 32'd0);
    chk("wr1_last", 32'(rs.l), 32'd1);
    chk("wr1_mem", mem[4], 32'hDEADBEEF);

    run("rd1", 1'b0, 32'h10, 3'd2, 1'b0, 0, 9, 0, 1);
    tr = tr_at(t0); rs = rs_at(r0);
    chk("rd1_htrans", 32'(tr.t), 32'(HTRANS_NONSEQ));
    chk("rd1_hburst", 32'(tr.bu), 32'd0);
    chk("rd1_hwrite", 32'(tr.w), 32'd0);
    chk("rd1_rdata", rs.d, 32'hDEADBEEF);
    chk("rd1_err", 32'(rs.e), 32'd0);
    chk("rd1_last", 32'(rs.l), 32'd1);

    // INCR4 write 1..4 then INCR4 read
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    run("wr4", 1'b1, 32'h20, 3'd2, 1'b1, 4, 9, 0, 4);
    chk("wr4_ntrans", 32'(tq.size() - t0), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("wr4_mem%0d", i), mem[8 + i], 32'(i + 1));

    run("rd4", 1'b0, 32'h20, 3'd2, 1'b1, 0, 9, 0, 4);
    chk("rd4_ntrans", 32'(tq.size() - t0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      tr = tr_at(t0 + i); rs = rs_at(r0 + i);
      chk($sformatf("rd4_htrans%0d", i), 32'(tr.t), (i == 0) ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_SEQ));
      chk($sformatf("rd4_haddr%0d", i), tr.a, 32'h20 + 32'(4 * i));
      chk($sformatf("rd4_hburst%0d", i), 32'(tr.bu), 32'd3);
      chk($sformatf("rd4_rdata%0d", i), rs.d, 32'(i + 1));
      chk($sformatf("rd4_last%0d", i), 32'(rs.l), (i == 3) ? 32'd1 : 32'd0);
    end

    // INCR4 write with a 2-cycle data gap before beat 2
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 5);
    exp_t = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ};
    exp_a = '{32'h20, 32'h24, 32'h28, 32'h28, 32'h28, 32'h2C};
    run("gap", 1'b1, 32'h20, 3'd2, 1'b1, 4, 2, 2, 4);
    chk("gap_ntrans", 32'(tq.size() - t0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      tr = tr_at(t0 + i);
      chk($sformatf("gap_htrans%0d", i), 32'(tr.t), 32'(exp_t[i]));
      chk($sformatf("gap_haddr%0d", i), tr.a, exp_a[i]);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("gap_mem%0d", i), mem[8 + i], 32'(i + 5));
    chk("gap_last", 32'(rs_at(r0 + 3).l), 32'd1);

    // byte and halfword lanes
    wbuf[0] = 32'h0000AB00;
    run("wrb", 1'b1, 32'h41, 3'd0, 1'b0, 1, 9, 0, 1);
    chk("wrb_hsize", 32'(tr_at(t0).sz), 32'd0);
    wbuf[0] = 32'h12340000;
    run("wrh", 1'b1, 32'h42, 3'd1, 1'b0, 1, 9, 0, 1);
    chk("wrh_hsize", 32'(tr_at(t0).sz), 32'd1);
    run("rdw", 1'b0, 32'h40, 3'd2, 1'b0, 0, 9, 0, 1);
    chk("rdw_rdata_hi", 32'(rs_at(r0).d[31:8]), 32'h001234AB);

    // misaligned word command is rejected without bus traffic
    run("mis", 1'b0, 32'h22, 3'd2, 1'b0, 0, 9, 0, 1);
    rs = rs_at(r0);
    chk("mis_ntrans", 32'(tq.size() - t0), 32'd0);
    chk("mis_err", 32'(rs.e), 32'd1);
    chk("mis_last", 32'(rs.l), 32'd1);
    chk("mis_rdata", rs.d, 32'h0);
    chk("mis_lat", rs.c - 32'(hs_cyc), 32'd1);

    // two-cycle ERROR on beat 1 of an INCR4 read
    err_addr = 32'h24;
    err_arm  = 1'b1;
    e0 = n_errcyc;
    run("err", 1'b0, 32'h20, 3'd2, 1'b1, 0, 9, 0, 2);
    err_arm = 1'b0;
    chk("err_ntrans", 32'(tq.size() - t0), 32'd2);
    chk("err_errcycles", 32'(n_errcyc - e0), 32'd1);
    chk("err_htrans_first", 32'(errcyc_trans), 32'(HTRANS_IDLE));
    rs = rs_at(r0);
    chk("err_rsp0_err", 32'(rs.e), 32'd0);
    chk("err_rsp0_last", 32'(rs.l), 32'd0);
    chk("err_rsp0_rdata", rs.d, 32'd5);
    rs = rs_at(r0 + 1);
    chk("err_rsp1_err", 32'(rs.e), 32'd1);
    chk("err_rsp1_last", 32'(rs.l), 32'd1);

    // reset in the middle of an INCR4 read
    @(posedge HCLK); #1;
    r0 = rq.size();
    send_cmd(1'b0, 32'h20, 3'd2, 1'b1, hs);
    chk("rst_mid_hs", 32'(hs), 32'd1);
    @(negedge HCLK);
    chk("rst_mid_pre_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    #2 HRESET = 1'b1;
    #1;
    chk("rst_mid_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_mid_haddr", HADDR, 32'h0);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("rst_mid_nrsp", 32'(rq.size() - r0), 32'd0);
    chk("rst_rsp_in_reset", 32'(rst_rsp), 32'd0);
    run("post", 1'b0, 32'h10, 3'd2, 1'b0, 0, 9, 0, 1);
    rs = rs_at(r0);
    chk("post_rdata", rs.d, 32'hDEADBEEF);
    chk("post_err", 32'(rs.e), 32'd0);
    chk("post_last", 32'(rs.l), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
